rr_grant_encoder: RTL
=====================

Name: rr_grant_encoder

Overview:
- Sequential 4-requester round-robin arbiter. Produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 decoder. The decoder converts gnt_idx into one-hot enables for the four shared-bus clients.
- Guarantees gnt_idx is stable for the whole grant tenure and holds 2'b00 whenever no grant is active.
- Provides a bounded hold time and a turnaround gap between tenures.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may stay active before forced release (legal range 2..255).
- CW, 8, width of the internal hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- req  input  4  request lines; bit i = requester i
- done  input  1  current owner releases the grant; sampled only in GRANT
- gnt_idx  output  2  index of granted requester (registered); 2'b00 when gnt_valid=0
- gnt_valid  output  1  grant active (registered)
- timeout  output  1  one-cycle pulse, asserted in the cycle after a forced release
- busy  output  1  high in GRANT and COOL states (combinational from state)

Behaviour:
- States: IDLE, GRANT, COOL. Internal registers: ptr[1:0] (last granted index), hold_cnt[CW-1:0].
- Reset (async, immediate on rst=1): state=IDLE, ptr=2'b11, hold_cnt=0, gnt_idx=2'b00, gnt_valid=0, timeout=0. With ptr=3, requester 0 has first priority after reset.
- Arbitration (IDLE only):
  - Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4 wrap-around); the first set req bit wins.
  - If any req bit is set at a rising edge in IDLE: next state GRANT, gnt_idx=winner, gnt_valid=1, ptr=winner, hold_cnt=0.
  - Latency is 1 cycle from the sampled request to visible grant.
  - If req=0, stay in IDLE; outputs unchanged.
- GRANT: hold_cnt increments by 1 every edge. Release conditions are evaluated each edge in this priority order:
  1. done=1 -> COOL, timeout=0.
  2. req[gnt_idx]=0 (requester dropped) -> COOL, timeout=0.
  3. hold_cnt==MAX_HOLD-1 -> COOL, timeout=1 (forced release).
  - If none apply: stay in GRANT; gnt_idx and gnt_valid unchanged.
  - If done and the timeout condition coincide, this is a normal release: timeout=0.
- On entry to COOL: gnt_valid=0, gnt_idx=2'b00, hold_cnt=0.
- COOL: lasts exactly one cycle, then IDLE unconditionally; timeout returns to 0 at that edge. req is ignored in COOL.
- Minimum spacing: a release sampled at edge k gives gnt_valid=0 after k. The earliest next grant is visible after edge k+2, i.e. a 2-cycle gap with gnt_valid=0.
- Maximum tenure: exactly MAX_HOLD cycles of gnt_valid=1.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,…
- done outside GRANT is ignored. req changes on non-owner bits during GRANT have no effect.
- Reset mid-GRANT or mid-COOL: outputs clear immediately (asynchronously) and ptr returns to 3.
- gnt_idx never takes X or Z values; downstream relies on gnt_idx=2'b00 whenever gnt_valid=0.

Test Plan:
- Reset then req=4'b0001 held, done pulsed 3 cycles after grant -> gnt_idx=0 and gnt_valid=1 one cycle after req; tenure 3 cycles; 2-cycle gap; then regrant to 0 (sole requester), ptr=0.
- req=4'b1111 held, done pulsed every grant after 1 cycle -> gnt_idx sequence 0,1,2,3,0 with 2 idle cycles between each.
- req=4'b0100 held, done=0 -> gnt_valid high for exactly 8 cycles; timeout=1 for one cycle after release; regrant to 2 after the gap.
- After granting 3, set req=4'b1001 -> next grant is 0 (wrap-around), not 3.
- During GRANT to 1, drop req[1] -> release next edge, timeout=0; done and the timeout condition asserted on the same edge -> timeout=0.
- Assert rst mid-GRANT (between clock edges) -> gnt_valid=0 and gnt_idx=00 immediately; after release with req=4'b1000, first grant is 3 and gnt_idx is never X.

Source files
------------

// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter with registered grant index, bounded
// hold time and a fixed one-cycle cool-down between grant tenures.
module rr_grant_encoder #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] hold_cnt, hold_cnt_n;
    logic [1:0]    gnt_idx_n;
    logic          gnt_valid_n;
    logic          timeout_n;

    logic [1:0]    winner;
    logic          found;
    logic [1:0]    cand;

    // Rotating priority: search starts one past the last winner, so the
    // previous owner is considered last.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = gnt_valid;
        timeout_n   = timeout;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    gnt_idx_n   = winner;
                    gnt_valid_n = 1'b1;
                    ptr_n       = winner;
                    hold_cnt_n  = '0;
                end
            end
            GRANT: begin
                hold_cnt_n = hold_cnt + CW'(1);
                // done wins over the hold limit, so a coincident release is normal.
                if (done || !req[gnt_idx] || (hold_cnt == CW'(MAX_HOLD - 1))) begin
                    state_n     = COOL;
                    gnt_idx_n   = 2'b00;
                    gnt_valid_n = 1'b0;
                    hold_cnt_n  = '0;
                    timeout_n   = !done && req[gnt_idx];
                end
            end
            COOL: begin
                state_n   = IDLE;
                timeout_n = 1'b0;
            end
            default: begin
                state_n     = IDLE;
                gnt_idx_n   = 2'b00;
                gnt_valid_n = 1'b0;
                hold_cnt_n  = '0;
                timeout_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'b11;
            hold_cnt  <= '0;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

    assign busy = (state == GRANT) || (state == COOL);

endmodule
